// File: rtl/input_playback_scheduler.sv
// sync_fifo: single-clock circular-buffer FIFO, no bypass (a push becomes head on the next cycle).
// Latency: 1 clk from push to head_vld; pop takes effect at the consuming edge.
// Backpressure: push_rdy = occupancy != DEPTH, derived from registered count only.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_vld,
    output logic                       push_rdy,
    input  logic [W-1:0]               push_dat,
    output logic                       head_vld,
    input  logic                       head_rdy,
    output logic [W-1:0]               head_dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign push_rdy = (cnt_q != CW'(DEPTH));
    assign head_vld = (cnt_q != '0);
    assign head_dat = mem_q[rd_ptr_q];
    assign count    = cnt_q;

    always_comb begin
        do_push  = push_vld & push_rdy;
        do_pop   = head_vld & head_rdy;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // Simultaneous push and pop leave occupancy unchanged.
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset; emptiness is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end
endmodule

// input_playback_scheduler: frame-timed replay of host events onto the core's input buses.
// Latency: an eligible head event reaches its output 1 clk later; one event per clk at most.
// Backpressure: evt_ready_o deasserts when DEPTH events are queued; a future-frame head blocks the queue.
module input_playback_scheduler #(
    parameter int         DEPTH    = 8,
    parameter int         FRAME_W  = 16,
    parameter logic [7:0] SW1_INIT = 8'h00,
    parameter logic [7:0] SW2_INIT = 8'h00
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     vsync_i,
    input  logic                     evt_valid_i,
    output logic                     evt_ready_o,
    input  logic [FRAME_W-1:0]       evt_frame_i,
    input  logic [2:0]               evt_target_i,
    input  logic [9:0]               evt_data_i,
    output logic [9:0]               playerinput_o,
    output logic [7:0]               trakball_o,
    output logic [7:0]               joystick_o,
    output logic [7:0]               sw1_o,
    output logic [7:0]               sw2_o,
    output logic [FRAME_W-1:0]       frame_o,
    output logic [$clog2(DEPTH):0]   pending_o,
    output logic                     late_o
);
    typedef struct packed {
        logic [FRAME_W-1:0] frame;
        logic [2:0]         target;
        logic [9:0]         data;
    } evt_t;

    localparam int EW = $bits(evt_t);

    evt_t   in_evt;
    evt_t   head;
    logic   head_vld;
    logic   head_due;
    logic   tick;

    logic               vsync_q,  vsync_d;
    logic [FRAME_W-1:0] frame_q,  frame_d;
    logic [9:0]         player_q, player_d;
    logic [7:0]         joy_q,    joy_d;
    logic [7:0]         trak_q,   trak_d;
    logic [7:0]         sw1_q,    sw1_d;
    logic [7:0]         sw2_q,    sw2_d;
    logic               late_q,   late_d;

    assign in_evt.frame  = evt_frame_i;
    assign in_evt.target = evt_target_i;
    assign in_evt.data   = evt_data_i;

    sync_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_evt_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (evt_valid_i),
        .push_rdy (evt_ready_o),
        .push_dat (in_evt),
        .head_vld (head_vld),
        .head_rdy (head_due),
        .head_dat (head),
        .count    (pending_o)
    );

    // Eligibility compares against the pre-increment frame, so a same-cycle tick never pulls an event early.
    assign tick     = vsync_q & ~vsync_i;
    assign head_due = head_vld && (head.frame <= frame_q);

    always_comb begin
        vsync_d  = vsync_i;
        frame_d  = tick ? frame_q + FRAME_W'(1) : frame_q;
        player_d = player_q;
        joy_d    = joy_q;
        trak_d   = trak_q;
        sw1_d    = sw1_q;
        sw2_d    = sw2_q;
        late_d   = late_q;
        if (head_due) begin
            case (head.target)
                3'd0:    player_d = head.data;
                3'd1:    joy_d    = head.data[7:0];
                3'd2:    trak_d   = head.data[7:0];
                3'd3:    trak_d   = trak_q + head.data[7:0];
                3'd4:    sw1_d    = head.data[7:0];
                3'd5:    sw2_d    = head.data[7:0];
                3'd6:    frame_d  = FRAME_W'(head.data);
                default: ;
            endcase
            if (head.target != 3'd7 && head.frame < frame_q) begin
                late_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q  <= 1'b1;
            frame_q  <= '0;
            player_q <= 10'h3FF;
            joy_q    <= 8'hFF;
            trak_q   <= 8'h00;
            sw1_q    <= SW1_INIT;
            sw2_q    <= SW2_INIT;
            late_q   <= 1'b0;
        end else begin
            vsync_q  <= vsync_d;
            frame_q  <= frame_d;
            player_q <= player_d;
            joy_q    <= joy_d;
            trak_q   <= trak_d;
            sw1_q    <= sw1_d;
            sw2_q    <= sw2_d;
            late_q   <= late_d;
        end
    end

    assign playerinput_o = player_q;
    assign joystick_o    = joy_q;
    assign trakball_o    = trak_q;
    assign sw1_o         = sw1_q;
    assign sw2_o         = sw2_q;
    assign frame_o       = frame_q;
    assign late_o        = late_q;
endmodule

// File: doc/input_playback_scheduler.md
Name: input_playback_scheduler

Overview:
- Frame-synchronised stimulus scheduler for the centipede core's player-input, trackball, joystick and DIP-switch buses.
- A host (C++ harness or scripted ROM) pushes time-stamped events through a valid/ready port into a small FIFO.
- The block counts video frames from the core's vsync and drives each event onto the matching input bus when its frame number is reached.
- It replaces ad-hoc per-cycle poking of the core's input registers and makes simulation runs deterministic.

Parameters:
- DEPTH, 8, event FIFO entries (power of two, >=2).
- FRAME_W, 16, frame counter and timestamp width.
- SW1_INIT, 8'h00, reset value of sw1_o.
- SW2_INIT, 8'h00, reset value of sw2_o.

Ports:
- clk  in  1  system clock (core 12 MHz clock).
- reset  in  1  synchronous, active-high reset.
- vsync_i  in  1  core vsync, active low.
- evt_valid_i  in  1  event offered.
- evt_ready_o  out  1  FIFO can accept an event.
- evt_frame_i  in  FRAME_W  frame number at which to apply the event.
- evt_target_i  in  3  destination selector.
- evt_data_i  in  10  payload.
- playerinput_o  out  10  to core playerinput_i.
- trakball_o  out  8  to core trakball_i.
- joystick_o  out  8  to core joystick_i.
- sw1_o  out  8  to core sw1_i.
- sw2_o  out  8  to core sw2_i.
- frame_o  out  FRAME_W  current frame count.
- pending_o  out  $clog2(DEPTH)+1  FIFO occupancy.
- late_o  out  1  sticky flag: an event was applied after its frame.

Behaviour:
- Reset values (all decided on reset=1 at a clk edge):
  - playerinput_o=10'h3FF, joystick_o=8'hFF (active-low idle), trakball_o=8'h00.
  - sw1_o=SW1_INIT, sw2_o=SW2_INIT.
  - frame_o=0, pending_o=0, late_o=0, FIFO flushed, vsync_q=1.
- Reset mid-operation discards all queued events; it is never a partial apply.
- Frame tick: vsync_q registers vsync_i. tick = vsync_q & ~vsync_i (falling edge).
  - On tick, frame_o increments by one, modulo 2^FRAME_W; all-ones wraps to 0.
- Push: accepted when evt_valid_i & evt_ready_o at a clk edge.
  - evt_ready_o = (pending_o != DEPTH), from registered occupancy only, never from evt_valid_i.
- FIFO has no bypass: an event pushed into an empty FIFO becomes head on the next cycle.
- Apply: each cycle, if the FIFO is non-empty and head.frame <= frame_o (unsigned, registered pre-increment value), the head pops.
  - Its effect is visible on the outputs at the following edge; latency is 1 clk from eligibility.
  - At most one event applies per cycle. Several events due in the same frame apply on consecutive cycles in FIFO order.
  - Events are not reordered. A head with a future frame blocks all later entries.
  - If head.frame < frame_o at pop, late_o is set. late_o clears only on reset.
- Same-cycle tick and apply: the comparison uses frame_o before the increment. An event for frame N+1 applies on the cycle after the tick.
- Same-cycle push and pop: occupancy is unchanged, and both pointers advance.
- Target decode (evt_data_i bits used):
  - 0: playerinput_o <= data[9:0].
  - 1: joystick_o <= data[7:0].
  - 2: trakball_o <= data[7:0] (absolute).
  - 3: trakball_o <= trakball_o + data[7:0], mod 256. Signed deltas use two's complement; 8'hFF = -1.
  - 4: sw1_o <= data[7:0].
  - 5: sw2_o <= data[7:0].
  - 6: frame_o <= {data zero-extended} (frame reload). This overrides a same-cycle tick increment.
  - 7: reserved. The event is popped with no output effect and does not set late_o.
- Frame wrap: after frame_o wraps to 0, queued events with large timestamps stay blocked until reached again. The host must not queue across a wrap.
- Outputs are all registered; there is no combinational path from evt_* to the bus outputs.

Test Plan:
- Reset/idle: hold reset 3 clks, then release with no events → playerinput_o=3FF, joystick_o=FF, trakball_o=00, sw1_o=00, frame_o=0, evt_ready_o=1, late_o=0.
- Frame scheduling:
  - Stimulus: push {frame=2,tgt=0,data=3FE}, then 3 vsync falling edges.
  - Required: playerinput_o stays 3FF until frame_o=2, then reads 3FE one clk later; late_o=0.
- Burst and back-pressure:
  - Stimulus: push DEPTH+1 events all for frame 5 with evt_valid_i held.
  - Required: evt_ready_o drops after 8 accepts and pending_o=8. After frame 5, events drain one per clk in order and the 9th is accepted once ready returns.
- Trackball accumulate:
  - Stimulus: at frame 1, tgt=2 data=0xFE; at frame 1, tgt=3 data=0x03; at frame 2, tgt=3 data=0xFF.
  - Required: trakball_o=FE, then 01 (wrap), then 00.
- Late event and tick collision:
  - Stimulus: advance to frame 4, then push {frame=1,tgt=1,data=0x7F}.
  - Required: joystick_o=7F 2 clks after the push and late_o=1.
  - Stimulus: push a frame-5 event during the tick cycle.
  - Required: it applies the cycle after frame_o=5.
- Reset mid-operation:
  - Stimulus: queue 4 future events, then assert reset for 1 clk.
  - Required: pending_o=0, all outputs return to reset values, and no queued event is ever applied afterwards.
